// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the sync_ram_ctrl memory controller.
package ram_ctrl_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int BYTES              = DEFAULT_DATA_WIDTH / 8;
    localparam int MAX_BYTES          = 8;

    // Even parity per byte; callers zero-extend their word and keep the low bits.
    function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_BYTES*8-1:0] word);
        logic [MAX_BYTES-1:0] p;
        for (int i = 0; i < MAX_BYTES; i++) p[i] = ^word[i*8 +: 8];
        return p;
    endfunction

endpackage

// File: rtl/sync_ram_ctrl_ram_array.sv
// Single-port storage: per-lane write enable, registered read.
module ram_array
    import ram_ctrl_pkg::*;
#(
    parameter int NB         = 2,
    parameter int LANE_W     = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [NB-1:0]          be,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [NB*LANE_W-1:0]   wdata,
    output logic [NB*LANE_W-1:0]   rdata
);

    logic [NB*LANE_W-1:0] mem_q [DEPTH];
    logic [NB*LANE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++)
                if (be[i]) mem_q[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_ram_ctrl.sv
// Valid/ready RAM controller with post-reset clear, byte enables and range check.
// Optional per-byte parity storage and checking when MEM_PARITY_EN is defined.
module sync_ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    DEPTH        = 256,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_byte_en,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    wr_err,
    output logic                    clear_busy
`ifdef MEM_PARITY_EN
    ,input  logic                   inj_parity_err
`endif
);

    localparam int NB = DATA_WIDTH / 8;
`ifdef MEM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    req_ready_q, clear_busy_q, wr_err_q;
    logic                    in_range, accept, rd_acc;

    logic                    ram_we;
    logic [NB-1:0]           ram_be;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [NB*LANE_W-1:0]    ram_wdata, ram_rdata, clr_word, wr_word;

    assign in_range = {1'b0, req_addr} < DEPTH_L;
    assign accept   = req_valid & req_ready_q;
    assign rd_acc   = accept & ~req_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            clear_busy_q <= 1'b1;
            wr_err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wr_err_q <= 1'b0;
                    if (cnt_q == LAST) begin
                        state_q      <= ST_RUN;
                        req_ready_q  <= 1'b1;
                        clear_busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: wr_err_q <= accept & req_write & ~in_range;
            endcase
        end
    end

    // Lane layout: {parity, byte} when parity is enabled, plain byte otherwise.
    always_comb begin
        clr_word = '0;
        wr_word  = '0;
        for (int i = 0; i < NB; i++) begin
            clr_word[i*LANE_W +: 8] = CLEAR_VALUE[i*8 +: 8];
            wr_word[i*LANE_W +: 8]  = req_wdata[i*8 +: 8];
        end
`ifdef MEM_PARITY_EN
        for (int i = 0; i < NB; i++) begin
            clr_word[i*LANE_W + 8] = NB'(byte_parity((MAX_BYTES*8)'(CLEAR_VALUE))) >> i;
            wr_word[i*LANE_W + 8]  = NB'(byte_parity((MAX_BYTES*8)'(req_wdata))) >> i;
        end
        wr_word[8] = wr_word[8] ^ inj_parity_err;
`endif
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = cnt_q;
        ram_wdata = clr_word;
        if (state_q == ST_CLEAR) begin
            ram_we = ~reset;
            ram_be = '1;
        end else begin
            ram_addr  = in_range ? req_addr : '0;
            ram_wdata = wr_word;
            if (accept & req_write & in_range & ~reset) begin
                ram_we = 1'b1;
                ram_be = req_byte_en;
            end
        end
    end

    ram_array #(
        .NB(NB), .LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk(clock), .we(ram_we), .be(ram_be), .addr(ram_addr),
        .wdata(ram_wdata), .rdata(ram_rdata)
    );

    logic [READ_LATENCY:1]   vld_pipe_q;
    logic [READ_LATENCY:0]   vld_pipe_d;
    logic                    s1_oor_q, s1_par_err, s1_err;
    logic [DATA_WIDTH-1:0]   s1_data, s1_rdata, out_data;
    logic                    out_err;

    assign vld_pipe_d = {vld_pipe_q, rd_acc};

    always_ff @(posedge clock) begin
        if (reset) vld_pipe_q <= '0;
        else       vld_pipe_q <= vld_pipe_d[READ_LATENCY-1:0];
        s1_oor_q <= ~in_range;
    end

    always_comb begin
        s1_data    = '0;
        s1_par_err = 1'b0;
        for (int i = 0; i < NB; i++) s1_data[i*8 +: 8] = ram_rdata[i*LANE_W +: 8];
`ifdef MEM_PARITY_EN
        for (int i = 0; i < NB; i++)
            if (ram_rdata[i*LANE_W + 8] != (NB'(byte_parity((MAX_BYTES*8)'(s1_data))) >> i)) s1_par_err = 1'b1;
`endif
        s1_err   = s1_oor_q | s1_par_err;
        s1_rdata = s1_oor_q ? '0 : s1_data;
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] d2_q;
            logic                  e2_q;
            always_ff @(posedge clock) begin
                d2_q <= s1_rdata;
                e2_q <= s1_err;
            end
            assign out_data = d2_q;
            assign out_err  = e2_q;
        end else begin : g_lat1
            assign out_data = s1_rdata;
            assign out_err  = s1_err;
        end
    endgenerate

    assign req_ready  = req_ready_q;
    assign clear_busy = clear_busy_q;
    assign wr_err     = wr_err_q;
    assign rsp_valid  = vld_pipe_q[READ_LATENCY];
    assign rsp_rdata  = rsp_valid ? out_data : '0;
    assign rsp_err    = rsp_valid & out_err;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed bench: instance 0 default, 1 with READ_LATENCY=2, 2 with DEPTH=200, shared request bus.
module tb_sync_ram_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, inj = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_byte_en = '0;
    logic [2:0]  rdy, rv, re, we, busy;
    logic [15:0] rd [3];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

`ifdef MEM_PARITY_EN
    `define INJ_CONN , .inj_parity_err(inj)
`else
    `define INJ_CONN
`endif

    sync_ram_ctrl #(.READ_LATENCY(1)) u0 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_byte_en(req_byte_en), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
        .rsp_err(re[0]), .wr_err(we[0]), .clear_busy(busy[0]) `INJ_CONN);

    sync_ram_ctrl #(.READ_LATENCY(2)) u1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_byte_en(req_byte_en), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
        .rsp_err(re[1]), .wr_err(we[1]), .clear_busy(busy[1]) `INJ_CONN);

    sync_ram_ctrl #(.DEPTH(200)) u2 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_byte_en(req_byte_en), .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
        .rsp_err(re[2]), .wr_err(we[2]), .clear_busy(busy[2]) `INJ_CONN);

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!(&rdy) && n < 600) begin tick(); n++; end
        total++;
        if (!(&rdy)) begin bad++; $display("FAIL wait_ready: req_ready=%b required 111", rdy); end
    endtask

    task automatic req(input logic w, input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_byte_en = b;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    // Releases reset and counts clear cycles of u0 (and u2); also counts any response pulses.
    task automatic run_clear(output int c0, output int c2, output int rdy_seen, output int rsp_seen);
        c0 = 0; c2 = 0; rdy_seen = 0; rsp_seen = 0;
        reset = 1'b0;
        while (busy[0] && c0 < 1000) begin
            if (busy[2]) c2++;
            if (rdy[0]) rdy_seen++;
            if (|rv) rsp_seen++;
            c0++;
            tick();
        end
    endtask

    task automatic test_reset;
        int c0, c2, rs, rp;
        reset = 1'b1; tick(); tick();
        total++; if (rdy !== 3'b000)  begin bad++; $display("FAIL reset_ready: got %b required 000", rdy); end
        total++; if (rv !== 3'b000 || re !== 3'b000) begin bad++; $display("FAIL reset_rsp: valid=%b err=%b required 000", rv, re); end
        total++; if (rd[0] !== 16'h0 || rd[1] !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h %h required 0", rd[0], rd[1]); end
        total++; if (we !== 3'b000)   begin bad++; $display("FAIL reset_wr_err: got %b required 000", we); end
        total++; if (busy !== 3'b111) begin bad++; $display("FAIL reset_busy: got %b required 111", busy); end
        run_clear(c0, c2, rs, rp);
        total++; if (c0 != 256) begin bad++; $display("FAIL clear_len: got %0d required 256", c0); end
        total++; if (c2 != 200) begin bad++; $display("FAIL clear_len_d200: got %0d required 200", c2); end
        total++; if (rs != 0)   begin bad++; $display("FAIL clear_ready: ready high %0d cycles required 0", rs); end
        total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL ready_after_clear: got %b required 1", rdy[0]); end
        wait_ready();
        req(1'b0, 8'h7F, 16'h0, 2'b00);
        total++; if (rv[0] !== 1'b1 || rd[0] !== 16'h0000) begin bad++; $display("FAIL read_cleared: valid=%b data=%h required 1 0000", rv[0], rd[0]); end
    endtask

    task automatic test_byte_en;
        req(1'b1, 8'd5, 16'h1234, 2'b11);
        req(1'b1, 8'd5, 16'hABCD, 2'b10);
        req(1'b0, 8'd5, 16'h0, 2'b00);
        total++; if (rv[0] !== 1'b1 || rd[0] !== 16'hAB34 || re[0] !== 1'b0) begin bad++; $display("FAIL byte_en_l1: v=%b d=%h e=%b required 1 ab34 0", rv[0], rd[0], re[0]); end
        total++; if (rv[1] !== 1'b0) begin bad++; $display("FAIL lat2_early: valid=%b required 0", rv[1]); end
        tick();
        total++; if (rv[1] !== 1'b1 || rd[1] !== 16'hAB34 || re[1] !== 1'b0) begin bad++; $display("FAIL byte_en_l2: v=%b d=%h e=%b required 1 ab34 0", rv[1], rd[1], re[1]); end
        total++; if (rv[0] !== 1'b0 || rd[0] !== 16'h0) begin bad++; $display("FAIL pulse_l1: v=%b d=%h required 0 0000", rv[0], rd[0]); end
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 3; i++) req(1'b1, 8'(i), 16'(i), 2'b11);
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = 8'(i + 1);
            tick();
            total++; if (rv[0] !== 1'b1 || rd[0] !== 16'(i + 1)) begin bad++; $display("FAIL b2b_l1_%0d: v=%b d=%h required 1 %h", i, rv[0], rd[0], 16'(i + 1)); end
            total++; if (rv[1] !== (i > 0) || rd[1] !== 16'(i)) begin bad++; $display("FAIL b2b_l2_%0d: v=%b d=%h required %0d %h", i, rv[1], rd[1], (i > 0), 16'(i)); end
        end
        req_valid = 1'b0;
        tick();
        total++; if (rv[0] !== 1'b0 || rv[1] !== 1'b1 || rd[1] !== 16'h0003) begin bad++; $display("FAIL b2b_tail: v0=%b v1=%b d1=%h required 0 1 0003", rv[0], rv[1], rd[1]); end
        tick();
        total++; if (rv[1] !== 1'b0) begin bad++; $display("FAIL b2b_end: v1=%b required 0", rv[1]); end
    endtask

    task automatic test_out_of_range;
        req(1'b1, 8'd250, 16'hDEAD, 2'b11);
        total++; if (we[2] !== 1'b1 || we[0] !== 1'b0) begin bad++; $display("FAIL wr_err_pulse: d200=%b d256=%b required 1 0", we[2], we[0]); end
        tick();
        total++; if (we[2] !== 1'b0) begin bad++; $display("FAIL wr_err_len: got %b required 0", we[2]); end
        req(1'b0, 8'd250, 16'h0, 2'b00);
        total++; if (rv[2] !== 1'b1 || re[2] !== 1'b1 || rd[2] !== 16'h0) begin bad++; $display("FAIL rd_oor: v=%b e=%b d=%h required 1 1 0000", rv[2], re[2], rd[2]); end
        total++; if (rv[0] !== 1'b1 || re[0] !== 1'b0 || rd[0] !== 16'hDEAD) begin bad++; $display("FAIL rd_inrange_250: v=%b e=%b d=%h required 1 0 dead", rv[0], re[0], rd[0]); end
        req(1'b0, 8'd50, 16'h0, 2'b00);
        total++; if (rd[2] !== 16'h0 || re[2] !== 1'b0) begin bad++; $display("FAIL oor_alias50: d=%h e=%b required 0000 0", rd[2], re[2]); end
        req(1'b0, 8'd122, 16'h0, 2'b00);
        total++; if (rd[2] !== 16'h0 || re[2] !== 1'b0) begin bad++; $display("FAIL oor_alias122: d=%h e=%b required 0000 0", rd[2], re[2]); end
    endtask

    task automatic test_reset_mid;
        int c0, c2, rs, rp;
        req(1'b1, 8'd0, 16'hBEEF, 2'b11);
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL mid_clear_busy: got %b required 1", busy[0]); end
        reset = 1'b1; tick();
        run_clear(c0, c2, rs, rp);
        total++; if (c0 != 256) begin bad++; $display("FAIL restart_len: got %0d required 256", c0); end
        wait_ready();
        req(1'b0, 8'd0, 16'h0, 2'b00);
        total++; if (rd[0] !== 16'h0) begin bad++; $display("FAIL restart_addr0: got %h required 0000", rd[0]); end
        req(1'b1, 8'd7, 16'h0777, 2'b11);
        req(1'b0, 8'd7, 16'h0, 2'b00);
        reset = 1'b1;
        tick();
        total++; if (rv !== 3'b000) begin bad++; $display("FAIL flush_inflight: valid=%b required 000", rv); end
        run_clear(c0, c2, rs, rp);
        total++; if (rp != 0) begin bad++; $display("FAIL rsp_after_reset: %0d pulses required 0", rp); end
        wait_ready();
        req(1'b0, 8'd7, 16'h0, 2'b00);
        total++; if (rv[0] !== 1'b1 || rd[0] !== 16'h0) begin bad++; $display("FAIL cleared_addr7: v=%b d=%h required 1 0000", rv[0], rd[0]); end
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity;
        inj = 1'b1;
        req(1'b1, 8'd9, 16'h5AC3, 2'b11);
        inj = 1'b0;
        req(1'b0, 8'd9, 16'h0, 2'b00);
        total++; if (rv[0] !== 1'b1 || re[0] !== 1'b1 || rd[0] !== 16'h5AC3) begin bad++; $display("FAIL parity_inj: v=%b e=%b d=%h required 1 1 5ac3", rv[0], re[0], rd[0]); end
        req(1'b1, 8'd9, 16'h5AC3, 2'b11);
        req(1'b0, 8'd9, 16'h0, 2'b00);
        total++; if (re[0] !== 1'b0 || rd[0] !== 16'h5AC3) begin bad++; $display("FAIL parity_clean: e=%b d=%h required 0 5ac3", re[0], rd[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_byte_en();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
